// File: rtl/hex_display_decoder.sv
// Readback decoder for four active-low seven-segment digits into a hex value plus invalid flags.
// Optional HEX_DECODE_AUTO_EN: self-start from IDLE whenever a display input differs from its snapshot.
module hex_display_decoder (
  input  logic        CLOCK_125_p,
  input  logic        RESET,
  input  logic [6:0]  HEX0,
  input  logic [6:0]  HEX1,
  input  logic [6:0]  HEX2,
  input  logic [6:0]  HEX3,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] value,
  output logic [3:0]  invalid
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0][6:0] hex_in;
  logic [3:0][6:0] snap_q;
  logic [1:0]      idx_q;
  logic [15:0]     shadow_val_q, shadow_val_d;
  logic [3:0]      shadow_inv_q, shadow_inv_d;
  logic [15:0]     value_q;
  logic [3:0]      invalid_q;
  logic            load, step, publish;
  logic            auto_trig;
  logic [4:0]      cur;

  assign hex_in = {HEX3, HEX2, HEX1, HEX0};

`ifdef HEX_DECODE_AUTO_EN
  assign auto_trig = (hex_in != snap_q);
`else
  assign auto_trig = 1'b0;
`endif

  // Returns {invalid, nibble}; patterns are active-low, bit order g..a.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  assign cur = decode_glyph(snap_q[idx_q]);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    publish = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start || auto_trig) begin
          state_d = StScan;
          load    = 1'b1;
        end
      end
      StScan: begin
        step = 1'b1;
        if (idx_q == 2'd3) begin
          state_d = StDone;
          publish = 1'b1;
        end
      end
      StDone: begin
        if (start) begin
          state_d = StScan;
          load    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Last digit is merged combinationally so publish can copy a complete result.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_inv_d = shadow_inv_q;
    if (step) begin
      for (int i = 0; i < 4; i++) begin
        if (idx_q == 2'(i)) begin
          shadow_val_d[i*4 +: 4] = cur[3:0];
          shadow_inv_d[i]        = cur[4];
        end
      end
    end
  end

  always_ff @(posedge CLOCK_125_p or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      snap_q       <= {4{7'h7F}};
      idx_q        <= 2'd0;
      shadow_val_q <= 16'h0000;
      shadow_inv_q <= 4'b0000;
      value_q      <= 16'h0000;
      invalid_q    <= 4'b0000;
    end else begin
      state_q      <= state_d;
      shadow_val_q <= shadow_val_d;
      shadow_inv_q <= shadow_inv_d;
      if (load) begin
        snap_q <= hex_in;
        idx_q  <= 2'd0;
      end else if (step) begin
        idx_q <= idx_q + 2'd1;
      end
      if (publish) begin
        value_q   <= shadow_val_d;
        invalid_q <= shadow_inv_d;
      end
    end
  end

  assign busy    = (state_q == StScan);
  assign done    = (state_q == StDone);
  assign value   = value_q;
  assign invalid = invalid_q;

endmodule
